pc_register: RTL and testbench

//   Program-counter holding register for the single-cycle CPU datapath.

---
 rtl/pc_register.sv | 40 ++++
 tb/tb_pc_register.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pc_register.sv
// Program-counter holding register: loads Din when en is high, holds otherwise.
// Define PC_REG_MISALIGN_EN to add the word-alignment flag output misalign.
module pc_register #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              ALIGN_BITS  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] Din,
`ifdef PC_REG_MISALIGN_EN
  output logic             misalign,
`endif
  output logic [WIDTH-1:0] Dout
);

  // Power-up value matches the boot address so Dout is defined even without a reset.
  logic [WIDTH-1:0] pcReg = RESET_VALUE;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcReg <= RESET_VALUE;
    end else if (en) begin
      pcReg <= Din;
    end
  end

  assign Dout = pcReg;

  // Catch nonsensical alignment settings at elaboration time.
  if (ALIGN_BITS < 1 || ALIGN_BITS > WIDTH) begin : gBadAlign
    $error("pc_register: ALIGN_BITS out of range");
  end

`ifdef PC_REG_MISALIGN_EN
  assign misalign = |pcReg[ALIGN_BITS-1:0];
`endif

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register: vector table plus hand-written corner sequences,
// with expected values queued at drive time and popped when Dout is sampled.
module tb_pc_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
`ifdef PC_REG_MISALIGN_EN
  logic        misalign;
`endif

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] expQ[$];
  string       nameQ[$];

  pc_register #(
    .WIDTH(32),
    .RESET_VALUE(32'h0000_0000),
    .ALIGN_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .Din(Din),
`ifdef PC_REG_MISALIGN_EN
    .misalign(misalign),
`endif
    .Dout(Dout)
  );

  // 20 ns period so a 10 ns rst pulse can sit entirely between two rising edges.
  always #10 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] required);
    testCount++;
    if (actual !== required) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] exp;
    string       name;
    if (expQ.size() == 0) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    exp  = expQ.pop_front();
    name = nameQ.pop_front();
    compare(name, Dout, exp);
`ifdef PC_REG_MISALIGN_EN
    compare({name, "_misalign"}, {31'b0, misalign}, {31'b0, (exp[1:0] != 2'b00)});
`endif
  endtask

  task automatic applyStimulus(input string name, input logic r, input logic e,
                               input logic [31:0] d, input logic [31:0] exp);
    @(negedge clk);
    rst = r;
    en  = e;
    Din = d;
    expQ.push_back(exp);
    nameQ.push_back(name);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic addVec(input string name, input logic r, input logic e,
                        input logic [31:0] d, input logic [31:0] exp);
    vec_t v;
    v.name = name;
    v.rst  = r;
    v.en   = e;
    v.din  = d;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // No reset ever asserted, en high, incrementing Din.
    for (int k = 0; k < 4; k++) addVec($sformatf("load_%0d", k), 1'b0, 1'b1, 32'(k), 32'(k));
    // Stall while Din keeps moving, then resume.
    addVec("stall_a",        1'b0, 1'b0, 32'd4,  32'd3);
    addVec("stall_b",        1'b0, 1'b0, 32'd5,  32'd3);
    addVec("resume",         1'b0, 1'b1, 32'd6,  32'd6);
    // Reset beats enable, then load on release.
    addVec("rst_over_en",    1'b1, 1'b1, 32'd7,  32'd0);
    addVec("after_rst",      1'b0, 1'b1, 32'd8,  32'd8);
    // Reset held for three edges.
    addVec("rst_hold_10",    1'b1, 1'b1, 32'd10, 32'd0);
    addVec("rst_hold_11",    1'b1, 1'b1, 32'd11, 32'd0);
    addVec("rst_hold_12",    1'b1, 1'b1, 32'd12, 32'd0);
    addVec("rst_release_13", 1'b0, 1'b1, 32'd13, 32'd13);
    // Full-width values, and reset with en low.
    addVec("all_ones",       1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    addVec("hold_all_ones",  1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
    addVec("pattern",        1'b0, 1'b1, 32'hA5A5_5A5C, 32'hA5A5_5A5C);
    addVec("rst_en_low",     1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);

    // Power-up value must be visible before any edge.
    #1;
    compare("powerup", Dout, 32'h0000_0000);

    foreach (vecs[i]) applyStimulus(vecs[i].name, vecs[i].rst, vecs[i].en, vecs[i].din, vecs[i].exp);

    // Short rst pulse between edges must not disturb the register.
    applyStimulus("pre_pulse", 1'b0, 1'b1, 32'd21, 32'd21);
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    compare("pulse_no_effect", Dout, 32'd21);
    @(posedge clk);
    #1;
    compare("pulse_next_edge", Dout, 32'd21);
    applyStimulus("post_pulse", 1'b0, 1'b1, 32'd22, 32'd22);

    // Enable toggling between edges is irrelevant; only the edge value counts.
    @(negedge clk);
    Din = 32'd30;
    en  = 1'b1;
    #3 en = 1'b0;
    #3 en = 1'b1;
    #2 en = 1'b0;
    @(posedge clk);
    #1;
    compare("en_glitch_hold", Dout, 32'd22);

    // Alignment flag cases (flag compared inside checkOutput when enabled).
    applyStimulus("aligned_4",    1'b0, 1'b1, 32'h0000_0004, 32'h0000_0004);
    applyStimulus("misaligned_6", 1'b0, 1'b1, 32'h0000_0006, 32'h0000_0006);
    applyStimulus("rst_clears",   1'b1, 1'b1, 32'h0000_0006, 32'h0000_0000);

    compare("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
